pipe_select_adder: RTL

- Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on input and output.
- WIDTH operands are split into NBLK = WIDTH/BLK segments. Every segment precomputes sum and carry for carry-in 0 and for carry-in 1.
- Pipeline stage k resolves segment k's select from the registered carry of stage k-1, so each stage carries one segment mux only.
- Used as the wide-datapath adder in the arithmetic unit, where a full-width select chain would not meet timing.

---
 rtl/adder_pkg.sv | 29 ++
 rtl/csel_seg.sv | 26 ++
 rtl/pipe_select_adder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the segmented adders in the arithmetic unit.
//   nblk()          - number of BLK-bit segments in a WIDTH-bit operand
//   SEG_FLAG_W      - carry flags carried in one precompute bundle
//   seg_bundle_w()  - width of a per-segment bundle {sum1,cout1,sum0,cout0}
//   signed_ovf()    - two's-complement overflow from the operand/result MSBs
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int unsigned SEG_FLAG_W = 2;

    // Number of segments; WIDTH is expected to be a multiple of BLK.
    function automatic int unsigned nblk(input int unsigned width, input int unsigned blk);
        return width / blk;
    endfunction

    // Bundle holds both candidate sums plus both candidate carries.
    function automatic int unsigned seg_bundle_w(input int unsigned blk);
        return 2 * blk + SEG_FLAG_W;
    endfunction

    // Overflow when both addends share a sign and the result sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/csel_seg.sv
// ----------------------------------------------------------------------------
// csel_seg
// Combinational carry-select segment: adds two BLK-bit slices for both
// possible carry-ins so the real carry only has to pick one result later.
// Ports:
//   a, b         - BLK-bit operand slices
//   sum0, cout0  - sum / carry-out assuming carry-in 0
//   sum1, cout1  - sum / carry-out assuming carry-in 1
// ----------------------------------------------------------------------------
module csel_seg #(
    parameter int unsigned BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    output logic [BLK-1:0] sum0,
    output logic           cout0,
    output logic [BLK-1:0] sum1,
    output logic           cout1
);

    localparam int unsigned EW = BLK + 1;

    assign {cout0, sum0} = {1'b0, a} + {1'b0, b};
    assign {cout1, sum1} = {1'b0, a} + {1'b0, b} + EW'(1);

endmodule

// File: rtl/pipe_select_adder.sv
// ----------------------------------------------------------------------------
// pipe_select_adder
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// The operand is split into NBLK = WIDTH/BLK segments; stage 0 precomputes
// every segment for both carry-ins and resolves segment 0, then stage k
// resolves segment k from the carry registered by stage k-1.
// Latency NBLK cycles, one result per cycle, bubble-collapsing flow control.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid / in_ready   - operand handshake
//   in_a, in_b            - WIDTH-bit operands
//   in_cin                - carry-in (ignored when in_sub=1)
//   in_sub                - 1: A-B, 0: A+B+cin
//   out_valid / out_ready - result handshake
//   out_sum               - WIDTH-bit result
//   out_cout              - MSB carry-out (subtract: 1 = no borrow)
//   out_ovf               - signed overflow
//
// Build option: PIPE_SELECT_ADDER_SAT_EN - saturate out_sum on signed
// overflow (0x7F..F / 0x80..0); out_ovf and out_cout stay raw.
// ----------------------------------------------------------------------------
module pipe_select_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned NBLK = nblk(WIDTH, BLK);
    localparam int unsigned BW   = seg_bundle_w(BLK);
    localparam int unsigned LAST = NBLK - 1;
    localparam int unsigned MSB  = WIDTH - 1;

    // Bundle layout: {sum1, cout1, sum0, cout0}
    function automatic logic [BLK-1:0] pick_sum(input logic [BW-1:0] bnd, input logic sel);
        return sel ? bnd[2*BLK+1 -: BLK] : bnd[BLK:1];
    endfunction

    function automatic logic pick_cy(input logic [BW-1:0] bnd, input logic sel);
        return sel ? bnd[BLK+1] : bnd[0];
    endfunction

    // ---------------- operand conditioning and segment precompute ----------
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [BW-1:0]    seg_pre [NBLK];

    assign b_eff = in_sub ? ~in_b : in_b;
    assign c_eff = in_sub | in_cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_seg
        logic [BLK-1:0] s0;
        logic [BLK-1:0] s1;
        logic           c0;
        logic           c1;

        csel_seg #(.BLK(BLK)) u_seg (
            .a     (in_a[g*BLK +: BLK]),
            .b     (b_eff[g*BLK +: BLK]),
            .sum0  (s0),
            .cout0 (c0),
            .sum1  (s1),
            .cout1 (c1)
        );

        assign seg_pre[g] = {s1, c1, s0, c0};
    end

    // ---------------- pipeline registers ----------------------------------
    logic [NBLK-1:0]  v_r;
    logic [WIDTH-1:0] sum_r  [NBLK];
    logic             cy_r   [NBLK];
    logic             amsb_r [NBLK];
    logic             bmsb_r [NBLK];
    logic [BW-1:0]    pre_r  [NBLK][NBLK];
    logic             ovf_r;

    // ---------------- flow control ----------------------------------------
    // en[k]: stage k may load this cycle (empty, or its content moves on).
    logic [NBLK-1:0] en;
    logic [NBLK-1:0] src_v;
    logic [NBLK-1:0] ld;

    always_comb begin : flow
        en       = '0;
        en[LAST] = !v_r[LAST] || out_ready;
        for (int k = int'(LAST) - 1; k >= 0; k--) begin
            en[k] = !v_r[k] || en[k+1];
        end
        src_v    = '0;
        src_v[0] = in_valid;
        for (int k = 1; k < int'(NBLK); k++) begin
            src_v[k] = v_r[k-1];
        end
        ld = en & src_v;
    end

    assign in_ready = en[0];

    // ---------------- sign bits seen by the last stage --------------------
    logic last_amsb;
    logic last_bmsb;

    if (NBLK == 1) begin : g_single
        assign last_amsb = in_a[MSB];
        assign last_bmsb = b_eff[MSB];
    end else begin : g_multi
        assign last_amsb = amsb_r[LAST-1];
        assign last_bmsb = bmsb_r[LAST-1];
    end

    // ---------------- per-stage select muxes ------------------------------
    logic [WIDTH-1:0] nsum [NBLK];
    logic             ncy  [NBLK];
    logic             ovf_n;

    always_comb begin : datapath
        nsum[0]          = '0;
        nsum[0][BLK-1:0] = pick_sum(seg_pre[0], c_eff);
        ncy[0]           = pick_cy(seg_pre[0], c_eff);
        for (int k = 1; k < int'(NBLK); k++) begin
            nsum[k]                = sum_r[k-1];
            nsum[k][k*BLK +: BLK] = pick_sum(pre_r[k-1][k], cy_r[k-1]);
            ncy[k]                 = pick_cy(pre_r[k-1][k], cy_r[k-1]);
        end

        // Overflow and optional clamp are folded into the last stage load.
        ovf_n = signed_ovf(last_amsb, last_bmsb, nsum[LAST][MSB]);
`ifdef PIPE_SELECT_ADDER_SAT_EN
        if (ovf_n) begin
            nsum[LAST]      = {WIDTH{~last_amsb}};
            nsum[LAST][MSB] = last_amsb;
        end
`endif
    end

    // ---------------- stage registers -------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r   <= '0;
            ovf_r <= 1'b0;
            for (int k = 0; k < int'(NBLK); k++) begin
                sum_r[k]  <= '0;
                cy_r[k]   <= 1'b0;
                amsb_r[k] <= 1'b0;
                bmsb_r[k] <= 1'b0;
                for (int j = 0; j < int'(NBLK); j++) begin
                    pre_r[k][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < int'(NBLK); k++) begin
                if (en[k]) begin
                    v_r[k] <= src_v[k];
                end
                if (ld[k]) begin
                    sum_r[k] <= nsum[k];
                    cy_r[k]  <= ncy[k];
                end
            end

            if (ld[0]) begin
                amsb_r[0] <= in_a[MSB];
                bmsb_r[0] <= b_eff[MSB];
                for (int j = 0; j < int'(NBLK); j++) begin
                    pre_r[0][j] <= seg_pre[j];
                end
            end

            for (int k = 1; k < int'(NBLK); k++) begin
                if (ld[k]) begin
                    amsb_r[k] <= amsb_r[k-1];
                    bmsb_r[k] <= bmsb_r[k-1];
                    for (int j = 0; j < int'(NBLK); j++) begin
                        pre_r[k][j] <= pre_r[k-1][j];
                    end
                end
            end

            if (ld[LAST]) begin
                ovf_r <= ovf_n;
            end
        end
    end

    // ---------------- outputs ---------------------------------------------
    assign out_valid = v_r[LAST];
    assign out_sum   = sum_r[LAST];
    assign out_cout  = cy_r[LAST];
    assign out_ovf   = ovf_r;

endmodule
